// File: rtl/demux_rr_dispatch_if.sv
// Handshake and status bundle between an upstream producer, the dispatcher and
// eight downstream channels sharing one data bus.
interface demux_rr_dispatch_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 16
);
  logic              mode;
  logic [7:0]        en_mask;
  logic [2:0]        fix_sel;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [7:0]        out_valid;
  logic [7:0]        out_ready;
  logic [DATA_W-1:0] out_data;
  logic [2:0]        sel;
  logic              busy;
  logic [CNT_W-1:0]  sent_cnt;

  modport master (
    output mode, en_mask, fix_sel, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, sel, busy, sent_cnt
  );

  modport slave (
    input  mode, en_mask, fix_sel, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, sel, busy, sent_cnt
  );
endinterface

// File: rtl/demux_rr_dispatch.sv
// One-deep dispatcher feeding a 1-to-8 demux: holds a word, picks its channel
// round-robin over an enable mask or from a fixed select, and counts deliveries.
module demux_rr_dispatch #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input logic               clk,
  input logic               rst_n,
  demux_rr_dispatch_if.slave bus
);

  localparam int unsigned N_CH  = 8;
  localparam int unsigned SEL_W = 3;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [N_CH-1:0]   valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              tgt_ok;
  logic              pop;
  logic              push;
  logic              in_ready_c;
  logic [SEL_W-1:0]  search_base;
  logic [SEL_W-1:0]  rr_sel;
  logic              rr_found;
  logic [SEL_W-1:0]  target;

  // Handshake qualifiers; a pop frees the slot in the same cycle for back-to-back flow
  always_comb begin
    tgt_ok     = bus.mode | (|bus.en_mask);
    pop        = (state_q == ST_FULL) & bus.out_ready[sel_q];
    in_ready_c = rst_n & tgt_ok & ((state_q == ST_EMPTY) | bus.out_ready[sel_q]);
    push       = bus.in_valid & in_ready_c;
  end

  // Round-robin search starts after the last-served channel; a concurrent pop counts as served
  always_comb begin
    rr_sel      = '0;
    rr_found    = 1'b0;
    search_base = pop ? sel_q : ptr_q;
    for (int unsigned i = 1; i <= N_CH; i++) begin
      if (!rr_found && bus.en_mask[SEL_W'(search_base + SEL_W'(i))]) begin
        rr_found = 1'b1;
        rr_sel   = SEL_W'(search_base + SEL_W'(i));
      end
    end
    target = bus.mode ? bus.fix_sel : rr_sel;
  end

  // Next-state and held-word update
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    valid_d = valid_q;
    data_d  = data_q;
    cnt_d   = cnt_q;

    if (pop) begin
      ptr_d = sel_q;
      cnt_d = cnt_q + CNT_W'(1);
    end

    case (state_q)
      ST_EMPTY: if (push) state_d = ST_FULL;
      ST_FULL:  if (pop && !push) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase

    if (push) begin
      sel_d   = target;
      data_d  = bus.in_data;
      valid_d = N_CH'(1) << target;
    end else if (pop) begin
      valid_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      sel_q   <= '0;
      ptr_q   <= '1;
      valid_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.sel       = sel_q;
  assign bus.busy      = (state_q == ST_FULL);
  assign bus.sent_cnt  = cnt_q;

endmodule

// File: doc/demux_rr_dispatch.md
Name: demux_rr_dispatch

Overview:
- Sequencing controller for a 1-to-8 demultiplexer datapath.
- Accepts a word stream on one valid/ready input and registers each word with a 3-bit target channel.
- Presents the word to exactly one of 8 output channels.
- Target selection is round-robin over an enable mask, or a fixed channel; this replaces manually driven select lines with a handshaked scheduler.

Parameters:
- DATA_W, 8, width of the data word.
- CNT_W, 16, width of the delivered-word counter.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- mode  input  1  0 = round-robin over en_mask, 1 = fixed channel fix_sel
- en_mask  input  8  per-channel enable for round-robin
- fix_sel  input  3  target channel in fixed mode
- in_valid  input  1  upstream word valid
- in_ready  output  1  dispatcher can accept a word this cycle
- in_data  input  DATA_W  upstream word
- out_valid  output  8  one-hot valid, bit = held target channel
- out_ready  input  8  per-channel downstream ready
- out_data  output  DATA_W  shared data bus to all channels
- sel  output  3  target channel of the held word (demux select)
- busy  output  1  a word is held
- sent_cnt  output  CNT_W  count of completed output transfers

Behaviour:
- Reset is asynchronous on rst_n low and released synchronously to clk.
  - Reset values: state EMPTY, out_valid = 0, out_data = 0, sel = 0, busy = 0, sent_cnt = 0, last-served pointer ptr = 7.
  - in_ready is 0 while rst_n is low.
- States:
  - EMPTY: no word held.
  - FULL: one word held; busy = 1; out_valid = (1 << sel); other out_valid bits are 0.
- Output transfer ("pop"): occurs on a clock edge in FULL when out_ready[sel] = 1.
  - out_ready bits of non-target channels are ignored.
- Input transfer ("push"): occurs on a clock edge when in_valid and in_ready are both 1.
- Target available ("tgt_ok"):
  - mode 0: en_mask != 0.
  - mode 1: always true; en_mask is ignored.
- in_ready = tgt_ok and (state EMPTY, or state FULL with out_ready[sel] = 1).
  - Combinational path out_ready to in_ready is allowed, giving back-to-back throughput of 1 word/cycle.
- Target computation at push:
  - mode 0: first channel with en_mask bit set, searching ptr+1, ptr+2, … wrapping modulo 8. The search includes ptr itself last.
  - mode 1: fix_sel.
  - Registered into sel; in_data is registered into out_data.
- ptr update: on every pop, ptr <= sel. With simultaneous pop and push, the new target search starts from the channel being popped (sel+1).
- State transitions:
  - EMPTY: push -> FULL.
  - FULL: pop without push -> EMPTY. pop with push -> FULL with the new word. No pop -> hold.
- Held word is sticky:
  - Changes to mode, en_mask or fix_sel while FULL do not alter sel, out_data or out_valid.
  - The held word is delivered to its original channel even if that channel is now disabled.
- in_data, sel and out_data change only on push. out_data holds its last value after pop.
- sent_cnt increments by 1 on each pop and wraps modulo 2^CNT_W.
- Latency: word accepted at edge N is visible on out_valid/out_data after edge N. Earliest pop is edge N+1.
- Reset mid-operation: a held word is discarded, with no pop and no count. ptr returns to 7.
- No backpressure timeout: FULL may persist indefinitely.

Test Plan:
- Reset, then mode=0, en_mask=8'hFF, in_valid held 1 with data 8'h10..8'h17, all out_ready=1 -> one transfer per cycle on channels 0,1,…,7 in order; out_valid = 01,02,04,…,80; sent_cnt = 8.
- mode=0, en_mask=8'b1010_0101, 6 words -> targets 0,2,5,7,0,2.
- en_mask=0 in mode 0 -> in_ready=0 and no push. Then en_mask=8'h08 -> next word goes to channel 3.
- Word held for channel 4 with out_ready[4]=0 for 5 cycles, other out_ready=1 -> out_valid stays 8'h10 and in_ready=0. Clearing en_mask[4] mid-hold leaves sel=4. Raising out_ready[4] -> pop.
- mode=1, fix_sel=6, 3 back-to-back words with out_ready[6]=1 -> all on channel 6; ptr=6. Then switch to mode=0, en_mask=8'hFF -> next word goes to channel 7, then 0.
- Assert rst_n=0 while FULL (sel=2, out_data=8'hA5) -> outputs immediately return to reset values; sent_cnt=0. After release, first word goes to channel 0.
